wave_envelope: RTL and testbench

- Upstream conditioning stage for the bar-graph renderer.
- Takes raw 12-bit offset-binary microphone samples and rectifies them. Tracks the peak magnitude over a fixed window of samples.
- Once per window it emits a 10-bit `wave_sample` plus a 1-cycle `wave_valid` strobe.
  - Bit 9 is the above-noise-floor gate.
  - Bits 8:0 are the scaled level consumed by the bar display.

---
 rtl/wave_envelope.sv | 170 +++++++++++++++++
 tb/tb_wave_envelope.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_envelope.sv
// -----------------------------------------------------------------------------
// wave_envelope
//   Upstream conditioning stage for the bar-graph renderer. Rectifies 12-bit
//   offset-binary microphone samples around midscale (2048), tracks the peak
//   magnitude over a window of WIN_LEN accepted samples, and once per window
//   emits a 10-bit {gate, level[8:0]} word with a one-cycle valid strobe.
//
//   Optional feature macro: WAVE_ENVELOPE_DECAY_EN
//     When defined, the emitted level falls by at most DECAY_STEP per window
//     (smooth release). When undefined, the level is the raw scaled peak and
//     no decay state or DECAY_STEP parameter exists.
//
// Ports
//   clk_sample   in   1   sample clock, all logic on rising edge
//   rst_n        in   1   asynchronous active-low reset
//   mic_in       in  12   offset-binary sample, 2048 = silence
//   mic_valid    in   1   mic_in valid this cycle (may be high every cycle)
//   wave_sample  out 10   {gate, level[8:0]}, held between windows
//   wave_valid   out  1   one-cycle pulse when wave_sample updates
//   peak_raw     out 11   rectified peak of the last completed window (debug)
// -----------------------------------------------------------------------------
module wave_envelope #(
  parameter int          WIN_LEN     = 64,      // 2..1024
  parameter logic [10:0] NOISE_FLOOR = 11'd64
`ifdef WAVE_ENVELOPE_DECAY_EN
  , parameter logic [8:0] DECAY_STEP = 9'd8
`endif
) (
  input  logic        clk_sample,
  input  logic        rst_n,
  input  logic [11:0] mic_in,
  input  logic        mic_valid,
  output logic [9:0]  wave_sample,
  output logic        wave_valid,
  output logic [10:0] peak_raw
);

  localparam int             CNT_W    = $clog2(WIN_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);
  localparam logic [8:0]     GATE_TH  = NOISE_FLOOR[10:2];

  typedef enum logic {ACCUM, EMIT} state_e;

  // Stage 0 registers
  logic [CNT_W-1:0] cnt_q;
  logic [10:0]      mag1_q;
  logic             v1_q;
  logic             last1_q;

  // Stage 1 / FSM registers
  state_e           state_q;
  logic [10:0]      peak_q;
  logic [10:0]      peak_raw_q;
  logic [9:0]       wave_sample_q;
  logic             wave_valid_q;

  // ---------------------------------------------------------------------------
  // Rectification: below midscale the distance is 2048-mic_in, which reaches
  // 2048 only for mic_in=0 and must saturate into 11 bits.
  // ---------------------------------------------------------------------------
  logic [11:0] neg_dist;
  logic [10:0] mag_d;

  // NOTE: every always_comb output gets a default first so no path can leave a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    neg_dist = 12'd2048 - mic_in;
    mag_d    = '0;
    if (mic_in[11]) begin
      mag_d = mic_in[10:0];
    end else if (neg_dist[11]) begin
      mag_d = 11'h7FF;
    end else begin
      mag_d = neg_dist[10:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mag1_q  <= '0;
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
    end else begin
      v1_q <= mic_valid;
      if (mic_valid) begin
        mag1_q  <= mag_d;
        last1_q <= (cnt_q == CNT_LAST);
        cnt_q   <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Window peak including the sample currently in stage 1, and the level that
  // would be emitted if this sample closes the window.
  // ---------------------------------------------------------------------------
  logic [10:0] wpk;
  logic [8:0]  new_level;
  logic [8:0]  level_out;
  logic        gate;

`ifdef WAVE_ENVELOPE_DECAY_EN
  logic [8:0] held_level;
  logic [8:0] decayed;

  always_comb begin
    held_level = wave_sample_q[8:0];
    decayed    = (held_level > DECAY_STEP) ? held_level - DECAY_STEP : 9'd0;
  end
`endif

  always_comb begin
    wpk       = (mag1_q > peak_q) ? mag1_q : peak_q;
    new_level = wpk[10:2];
`ifdef WAVE_ENVELOPE_DECAY_EN
    level_out = (new_level > decayed) ? new_level : decayed;
`else
    level_out = new_level;
`endif
    gate      = (level_out >= GATE_TH);
  end

  // ---------------------------------------------------------------------------
  // Accumulate / emit FSM. The output word is registered on the edge that
  // enters EMIT, so EMIT is exactly the cycle in which wave_valid is high and
  // the new wave_sample is visible (two cycles after the closing sample was
  // accepted). Accumulation continues in EMIT so no sample is lost.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ACCUM;
      peak_q        <= '0;
      peak_raw_q    <= '0;
      wave_sample_q <= '0;
      wave_valid_q  <= 1'b0;
    end else begin
      wave_valid_q <= 1'b0;
      case (state_q)
        ACCUM: begin
          if (v1_q && last1_q) begin
            peak_raw_q    <= wpk;
            peak_q        <= '0;
            wave_sample_q <= {gate, level_out};
            wave_valid_q  <= 1'b1;
            state_q       <= EMIT;
          end else if (v1_q) begin
            peak_q <= wpk;
          end
        end
        EMIT: begin
          // A window is at least two samples long, so the sample seen here
          // always belongs to the next window and never closes it.
          if (v1_q) begin
            peak_q <= wpk;
          end
          state_q <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign wave_sample = wave_sample_q;
  assign wave_valid  = wave_valid_q;
  assign peak_raw    = peak_raw_q;

endmodule

// File: tb/tb_wave_envelope.sv
// -----------------------------------------------------------------------------
// tb_wave_envelope
//   Directed bench for wave_envelope with WIN_LEN=4, NOISE_FLOOR=64.
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   on the falling edge. A monitor logs every wave_valid pulse.
// -----------------------------------------------------------------------------
module tb_wave_envelope;

  logic        clk_sample;
  logic        rst_n;
  logic [11:0] mic_in;
  logic        mic_valid;
  logic [9:0]  wave_sample;
  logic        wave_valid;
  logic [10:0] peak_raw;

  int tests_run = 0;
  int tests_failed = 0;

  wave_envelope #(
    .WIN_LEN     (4),
    .NOISE_FLOOR (11'd64)
  ) dut (
    .clk_sample  (clk_sample),
    .rst_n       (rst_n),
    .mic_in      (mic_in),
    .mic_valid   (mic_valid),
    .wave_sample (wave_sample),
    .wave_valid  (wave_valid),
    .peak_raw    (peak_raw)
  );

  initial clk_sample = 1'b0;
  always #5 clk_sample = ~clk_sample;

  // Pulse log, written on the falling edge.
  logic [9:0]  ws_log[$];
  logic [10:0] pk_log[$];
  logic        prev_valid = 1'b0;
  int          double_pulses = 0;

  always @(negedge clk_sample) begin
    if (wave_valid) begin
      ws_log.push_back(wave_sample);
      pk_log.push_back(peak_raw);
      if (prev_valid) double_pulses++;
    end
    prev_valid <= wave_valid;
  end

  // Reference rectifier.
  function automatic int rect(input int v);
    int m;
    if (v >= 2048) m = v - 2048;
    else m = 2048 - v;
    if (m > 2047) m = 2047;
    return m;
  endfunction

  task automatic drive(input logic [11:0] v);
    @(posedge clk_sample); #1;
    mic_in    = v;
    mic_valid = 1'b1;
  endtask

  task automatic idle();
    @(posedge clk_sample); #1;
    mic_valid = 1'b0;
    mic_in    = 12'd2048;
  endtask

  // Drive one 4-sample window and wait (bounded) for its pulse.
  task automatic run_window(input logic [11:0] a, input logic [11:0] b,
                            input logic [11:0] c, input logic [11:0] d,
                            output logic [9:0] ws, output logic [10:0] pk,
                            output bit ok);
    int n0;
    n0 = ws_log.size();
    drive(a); drive(b); drive(c); drive(d);
    idle();
    ok = 1'b0;
    ws = 'x;
    pk = 'x;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_sample);
      if (ws_log.size() > n0) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      ws = ws_log[n0];
      pk = pk_log[n0];
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    mic_in    = 12'd2048;
    mic_valid = 1'b0;
    #1 rst_n = 1'b0;
    #5;
    tests_run++;
    if ({wave_sample, wave_valid, peak_raw} !== 22'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ws=%h wv=%b pk=%0d, want all 0", wave_sample, wave_valid, peak_raw);
    end
    @(posedge clk_sample); @(posedge clk_sample); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic_latency();
    logic [9:0] ws_exp;
    ws_exp = 10'h225;
    drive(12'd2048); drive(12'd2100); drive(12'd1900); drive(12'd2048);
    idle();                       // this edge accepts the 4th sample (cycle N)
    @(negedge clk_sample);        // cycle N+1
    tests_run++;
    if (wave_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_early: wave_valid=%b at N+1, want 0", wave_valid);
    end
    @(negedge clk_sample);        // cycle N+2
    tests_run++;
    if (wave_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL latency_pulse: wave_valid=%b at N+2, want 1", wave_valid);
    end
    tests_run++;
    if (wave_sample !== ws_exp) begin
      tests_failed++;
      $display("FAIL basic_sample: ws=%h want %h", wave_sample, ws_exp);
    end
    tests_run++;
    if (peak_raw !== 11'd148) begin
      tests_failed++;
      $display("FAIL basic_peak: pk=%0d want 148", peak_raw);
    end
    @(negedge clk_sample);        // cycle N+3
    tests_run++;
    if (wave_valid !== 1'b0 || wave_sample !== ws_exp) begin
      tests_failed++;
      $display("FAIL pulse_width: wv=%b ws=%h, want 0 and held %h", wave_valid, wave_sample, ws_exp);
    end
  endtask

  task automatic test_decay();
    logic [9:0]  ws;
    logic [10:0] pk;
    logic [9:0]  ws_exp;
    bit          ok;
`ifdef WAVE_ENVELOPE_DECAY_EN
    ws_exp = 10'h21D;
`else
    ws_exp = 10'h000;
`endif
    run_window(12'd2048, 12'd2048, 12'd2048, 12'd2048, ws, pk, ok);
    tests_run++;
    if (!ok || ws !== ws_exp || pk !== 11'd0) begin
      tests_failed++;
      $display("FAIL decay_window: ok=%b ws=%h pk=%0d, want ws=%h pk=0", ok, ws, pk, ws_exp);
    end
  endtask

  task automatic test_saturation();
    logic [9:0]  ws;
    logic [10:0] pk;
    bit          ok;
    run_window(12'd0, 12'd0, 12'd0, 12'd0, ws, pk, ok);
    tests_run++;
    if (!ok || ws !== 10'h3FF || pk !== 11'd2047) begin
      tests_failed++;
      $display("FAIL sat_zero: ok=%b ws=%h pk=%0d, want ws=3ff pk=2047", ok, ws, pk);
    end
    run_window(12'd4095, 12'd4095, 12'd4095, 12'd4095, ws, pk, ok);
    tests_run++;
    if (!ok || ws !== 10'h3FF || pk !== 11'd2047) begin
      tests_failed++;
      $display("FAIL sat_full: ok=%b ws=%h pk=%0d, want ws=3ff pk=2047", ok, ws, pk);
    end
  endtask

  task automatic test_reset_mid_window();
    int n0;
    drive(12'd0); drive(12'd0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({wave_sample, wave_valid, peak_raw} !== 22'd0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: ws=%h wv=%b pk=%0d, want all 0", wave_sample, wave_valid, peak_raw);
    end
    @(posedge clk_sample); #1;
    rst_n = 1'b1;
    n0 = ws_log.size();
    drive(12'd2048); drive(12'd2048); drive(12'd2048);
    idle();
    repeat (4) @(posedge clk_sample);
    tests_run++;
    if (ws_log.size() != n0) begin
      tests_failed++;
      $display("FAIL midreset_partial: %0d pulses after 3 samples, want 0", ws_log.size() - n0);
    end
    drive(12'd2048);
    idle();
    repeat (4) @(posedge clk_sample);
    tests_run++;
    if (ws_log.size() != n0 + 1) begin
      tests_failed++;
      $display("FAIL midreset_count: %0d pulses after 4 samples, want 1", ws_log.size() - n0);
    end else if (ws_log[n0] !== 10'h000 || pk_log[n0] !== 11'd0) begin
      tests_failed++;
      $display("FAIL midreset_value: ws=%h pk=%0d, want 000 and 0", ws_log[n0], pk_log[n0]);
    end
  endtask

  task automatic test_below_floor();
    logic [9:0]  ws;
    logic [10:0] pk;
    bit          ok;
    run_window(12'd2050, 12'd2050, 12'd2050, 12'd2050, ws, pk, ok);
    tests_run++;
    if (!ok || ws !== 10'h000 || pk !== 11'd2) begin
      tests_failed++;
      $display("FAIL below_floor: ok=%b ws=%h pk=%0d, want ws=000 pk=2", ok, ws, pk);
    end
  endtask

  task automatic test_back_to_back();
    int          smp[40];
    int          n0, idx, cyc, held, pk, lvl;
    logic [9:0]  ws_exp;
    for (int i = 0; i < 40; i++) smp[i] = (i * 613 + 101) % 4096;
    n0 = ws_log.size();
    double_pulses = 0;
    idx = 0;
    cyc = 0;
    while (idx < 40) begin
      @(posedge clk_sample); #1;
      if (cyc % 3 == 2) begin
        mic_valid = 1'b0;
      end else begin
        mic_in    = 12'(smp[idx]);
        mic_valid = 1'b1;
        idx++;
      end
      cyc++;
    end
    idle();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_sample);
      if (ws_log.size() >= n0 + 10) break;
    end
    repeat (3) @(posedge clk_sample);
    tests_run++;
    if (ws_log.size() - n0 != 10) begin
      tests_failed++;
      $display("FAIL b2b_count: %0d pulses, want 10", ws_log.size() - n0);
    end
    tests_run++;
    if (double_pulses != 0) begin
      tests_failed++;
      $display("FAIL b2b_width: %0d stretched pulses, want 0", double_pulses);
    end
    held = 0;
    for (int w = 0; w < 10; w++) begin
      pk = 0;
      for (int k = 0; k < 4; k++) if (rect(smp[4*w+k]) > pk) pk = rect(smp[4*w+k]);
      lvl = pk / 4;
`ifdef WAVE_ENVELOPE_DECAY_EN
      if (held - 8 > lvl) lvl = held - 8;
`endif
      held   = lvl;
      ws_exp = {(lvl >= 16) ? 1'b1 : 1'b0, 9'(lvl)};
      if (n0 + w < ws_log.size()) begin
        tests_run++;
        if (ws_log[n0+w] !== ws_exp || pk_log[n0+w] !== 11'(pk)) begin
          tests_failed++;
          $display("FAIL b2b_window%0d: ws=%h pk=%0d, want ws=%h pk=%0d", w, ws_log[n0+w], pk_log[n0+w], ws_exp, pk);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_decay();
    test_saturation();
    test_reset_mid_window();
    test_below_floor();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
